chardisp_term_writer: RTL

- Bus initiator that drives the write port of the character display peripheral. It turns a byte stream of ASCII characters into VRAM entry writes.
- Keeps an 80x50 text cursor and handles CR, LF, BS, FF and line wrap.
- Clears the next line when the cursor moves onto it, and clears the whole screen at power-on and on FF.
- Sits between a byte source (UART RX, CPU FIFO) and the display's WRADDR/BYTEEN/WREN/WRDATA inputs, in the same clock domain.

---
 rtl/chardisp_term_writer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/chardisp_term_writer.sv
// chardisp_term_writer: turns a byte stream of ASCII characters into VRAM
// entry writes for the character display. Keeps an 80x50 text cursor,
// handles CR/LF/BS/FF and line wrap, and clears the screen at power-on and
// on FF, and the new line whenever the cursor moves onto it.
module chardisp_term_writer #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 50,
    parameter logic [6:0] CLR_CHAR = 7'h20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CHAR_VALID,
    input  logic [7:0]  CHAR_DATA,
    output logic        CHAR_READY,
    input  logic [13:0] ATTR,
    output logic [15:0] WRADDR,
    output logic [3:0]  BYTEEN,
    output logic        WREN,
    output logic [31:0] WRDATA,
    output logic        BUSY,
    output logic [6:0]  CURSOR_COL,
    output logic [5:0]  CURSOR_ROW
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_CLR_LINE = 2'd1;
    localparam logic [1:0]  ST_CLR_ALL  = 2'd2;

    localparam logic [6:0]  COL_LAST   = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST   = 6'(ROWS - 1);
    localparam logic [11:0] COLS_W     = 12'(COLS);
    localparam logic [11:0] ENTRY_LAST = 12'(ROWS * COLS - 1);

    logic [1:0]  r_state;
    logic [6:0]  r_col;
    logic [5:0]  r_row;
    logic [11:0] r_row_base;   // r_row * COLS, kept incrementally
    logic [11:0] r_clr_addr;   // next entry index to clear
    logic [11:0] r_clr_last;   // final entry index of the running clear
    logic        r_ready;
    logic        r_wren;
    logic [15:0] r_wraddr;
    logic [31:0] r_wrdata;

    logic        w_accept;
    logic        w_printable;
    logic        w_is_cr;
    logic        w_is_lf;
    logic        w_is_bs;
    logic        w_is_ff;
    logic        w_start_line;
    logic        w_start_all;
    logic [11:0] w_cur_entry;
    logic        w_row_wrap;
    logic [5:0]  w_next_row;
    logic [11:0] w_next_base;

    assign w_accept     = CHAR_VALID & r_ready & (r_state == ST_IDLE);
    assign w_printable  = (CHAR_DATA >= 8'h20) && (CHAR_DATA <= 8'h7E);
    assign w_is_cr      = (CHAR_DATA == 8'h0D);
    assign w_is_lf      = (CHAR_DATA == 8'h0A);
    assign w_is_bs      = (CHAR_DATA == 8'h08);
    assign w_is_ff      = (CHAR_DATA == 8'h0C);

    // A printable in the last column and LF both move onto a fresh line.
    assign w_start_line = w_accept & ((w_printable & (r_col == COL_LAST)) | w_is_lf);
    assign w_start_all  = w_accept & w_is_ff;

    assign w_cur_entry  = r_row_base + {5'd0, r_col};
    assign w_row_wrap   = (r_row == ROW_LAST);
    assign w_next_row   = w_row_wrap ? 6'd0 : r_row + 6'd1;
    assign w_next_base  = w_row_wrap ? 12'd0 : r_row_base + COLS_W;

    assign CHAR_READY = r_ready;
    assign WREN       = r_wren;
    assign WRADDR     = r_wraddr;
    assign WRDATA     = r_wrdata;
    assign BYTEEN     = r_wren ? 4'b0111 : 4'b0000;
    assign BUSY       = (r_state != ST_IDLE);
    assign CURSOR_COL = r_col;
    assign CURSOR_ROW = r_row;

    // Control FSM: cursor tracking, clear sequencing and the ready flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_CLR_ALL;
            r_col      <= 7'd0;
            r_row      <= 6'd0;
            r_row_base <= 12'd0;
            r_clr_addr <= 12'd0;
            r_clr_last <= ENTRY_LAST;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_start_line) begin
                        r_col      <= 7'd0;
                        r_row      <= w_next_row;
                        r_row_base <= w_next_base;
                        r_clr_addr <= w_next_base;
                        r_clr_last <= w_next_base + COLS_W - 12'd1;
                        r_state    <= ST_CLR_LINE;
                        r_ready    <= 1'b0;
                    end else if (w_start_all) begin
                        r_col      <= 7'd0;
                        r_row      <= 6'd0;
                        r_row_base <= 12'd0;
                        r_clr_addr <= 12'd0;
                        r_clr_last <= ENTRY_LAST;
                        r_state    <= ST_CLR_ALL;
                        r_ready    <= 1'b0;
                    end else if (w_accept) begin
                        if (w_printable) begin
                            r_col <= r_col + 7'd1;
                        end else if (w_is_cr) begin
                            r_col <= 7'd0;
                        end else if (w_is_bs && (r_col != 7'd0)) begin
                            r_col <= r_col - 7'd1;
                        end
                    end
                end
                ST_CLR_LINE, ST_CLR_ALL: begin
                    r_ready <= 1'b0;
                    if (r_clr_addr == r_clr_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + 12'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bus side: one registered VRAM write per clear step or accepted printable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wren   <= 1'b0;
            r_wraddr <= 16'd0;
            r_wrdata <= 32'd0;
        end else if (r_state != ST_IDLE) begin
            r_wren   <= 1'b1;
            r_wraddr <= {2'b00, r_clr_addr, 2'b00};
            r_wrdata <= {25'd0, CLR_CHAR};
        end else if (w_accept && w_printable) begin
            r_wren   <= 1'b1;
            r_wraddr <= {2'b00, w_cur_entry, 2'b00};
            r_wrdata <= {10'd0, ATTR, 1'b0, CHAR_DATA[6:0]};
        end else begin
            r_wren   <= 1'b0;
        end
    end

endmodule
